// File: rtl/mesi_isc_proto_mon.sv
// Passive MESI ISC protocol monitor: per-port broadcast/snoop trackers and sticky error log.
// Optional broadcast statistics outputs are enabled by defining MESI_ISC_MON_STATS_EN.
module mesi_isc_proto_mon #(
   parameter int CPU_COUNT      = 4,
   parameter int ADDR_WIDTH     = 32,
   parameter int MBUS_CMD_WIDTH = 3,
   parameter int CBUS_CMD_WIDTH = 3,
   parameter int TIMEOUT_CYCLES = 64,
   parameter int TIMER_WIDTH    = 7,
   parameter int ERR_CNT_WIDTH  = 8
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                clr_i,
   input  logic [CPU_COUNT*MBUS_CMD_WIDTH-1:0] mbus_cmd_i,
   input  logic [CPU_COUNT*ADDR_WIDTH-1:0]     mbus_addr_i,
   input  logic [CPU_COUNT-1:0]                mbus_ack_i,
   input  logic [CPU_COUNT*CBUS_CMD_WIDTH-1:0] cbus_cmd_i,
   input  logic [ADDR_WIDTH-1:0]               cbus_addr_i,
   input  logic [CPU_COUNT-1:0]                cbus_ack_i,
`ifdef MESI_ISC_MON_STATS_EN
   output logic [15:0]                         stat_bcast_cnt_o,
   output logic [TIMER_WIDTH-1:0]              stat_max_lat_o,
`endif
   output logic [7:0]                          err_o,
   output logic [2:0]                          err_first_code_o,
   output logic [2:0]                          err_first_port_o,
   output logic [ERR_CNT_WIDTH-1:0]            err_cnt_o,
   output logic                                busy_o
);

   localparam logic [MBUS_CMD_WIDTH-1:0] MBUS_WR       = MBUS_CMD_WIDTH'(1);
   localparam logic [MBUS_CMD_WIDTH-1:0] MBUS_WR_BROAD = MBUS_CMD_WIDTH'(3);
   localparam logic [MBUS_CMD_WIDTH-1:0] MBUS_RD_BROAD = MBUS_CMD_WIDTH'(4);
   localparam logic [CBUS_CMD_WIDTH-1:0] CBUS_NOP      = CBUS_CMD_WIDTH'(0);
   localparam logic [CBUS_CMD_WIDTH-1:0] CBUS_EN_RD    = CBUS_CMD_WIDTH'(4);
   localparam logic [TIMER_WIDTH-1:0]    TIMER_LAST    = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);

   typedef enum logic {BC_IDLE, BC_PEND} bc_state_t;
   typedef enum logic {SN_IDLE, SN_WAIT} sn_state_t;

   bc_state_t                 bc_state   [CPU_COUNT];
   bc_state_t                 bc_state_n [CPU_COUNT];
   logic [TIMER_WIDTH-1:0]    bc_timer   [CPU_COUNT];
   logic [TIMER_WIDTH-1:0]    bc_timer_n [CPU_COUNT];
   logic [MBUS_CMD_WIDTH-1:0] bc_cmd     [CPU_COUNT];
   logic [MBUS_CMD_WIDTH-1:0] bc_cmd_n   [CPU_COUNT];
   logic [ADDR_WIDTH-1:0]     bc_addr    [CPU_COUNT];
   logic [ADDR_WIDTH-1:0]     bc_addr_n  [CPU_COUNT];

   sn_state_t                 sn_state   [CPU_COUNT];
   sn_state_t                 sn_state_n [CPU_COUNT];
   logic [TIMER_WIDTH-1:0]    sn_timer   [CPU_COUNT];
   logic [TIMER_WIDTH-1:0]    sn_timer_n [CPU_COUNT];
   logic [CBUS_CMD_WIDTH-1:0] sn_cmd     [CPU_COUNT];
   logic [CBUS_CMD_WIDTH-1:0] sn_cmd_n   [CPU_COUNT];
   logic [ADDR_WIDTH-1:0]     sn_addr    [CPU_COUNT];
   logic [ADDR_WIDTH-1:0]     sn_addr_n  [CPU_COUNT];

   logic [CPU_COUNT-1:0]      ack_q;
   logic [CPU_COUNT-1:0]      ev_port [8];
   logic [7:0]                ev;
   logic [2:0]                first_code;
   logic [2:0]                first_port;
   logic                      code_found;
   logic                      port_found;

   logic [MBUS_CMD_WIDTH-1:0] mc;
   logic [ADDR_WIDTH-1:0]     ma;
   logic [CBUS_CMD_WIDTH-1:0] cc;
   logic                      is_bcast;
   logic                      is_snoop;
   int unsigned               wr_cnt;

`ifdef MESI_ISC_MON_STATS_EN
   int unsigned               done_cnt;
   logic [TIMER_WIDTH-1:0]    lat_max;
   logic [16:0]               bcast_sum;
`endif

   // Tracker next-state and per-port error events
   always_comb begin
      wr_cnt   = 0;
      mc       = '0;
      ma       = '0;
      cc       = '0;
      is_bcast = 1'b0;
      is_snoop = 1'b0;
`ifdef MESI_ISC_MON_STATS_EN
      done_cnt = 0;
      lat_max  = '0;
`endif
      for (int unsigned c = 0; c < 8; c++) ev_port[c] = '0;

      for (int unsigned i = 0; i < CPU_COUNT; i++) begin
         bc_state_n[i] = bc_state[i];
         bc_timer_n[i] = bc_timer[i];
         bc_cmd_n[i]   = bc_cmd[i];
         bc_addr_n[i]  = bc_addr[i];
         sn_state_n[i] = sn_state[i];
         sn_timer_n[i] = sn_timer[i];
         sn_cmd_n[i]   = sn_cmd[i];
         sn_addr_n[i]  = sn_addr[i];

         mc       = mbus_cmd_i[i*MBUS_CMD_WIDTH +: MBUS_CMD_WIDTH];
         ma       = mbus_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
         cc       = cbus_cmd_i[i*CBUS_CMD_WIDTH +: CBUS_CMD_WIDTH];
         is_bcast = (mc == MBUS_WR_BROAD) || (mc == MBUS_RD_BROAD);
         is_snoop = (cc != CBUS_NOP) && (cc <= CBUS_EN_RD);

         if (mc > MBUS_RD_BROAD)             ev_port[0][i] = 1'b1;
         if (cc > CBUS_EN_RD)                ev_port[1][i] = 1'b1;
         if (mc == MBUS_WR)                  wr_cnt++;
         if (mbus_ack_i[i] && ack_q[i])      ev_port[3][i] = 1'b1;

         case (bc_state[i])
            BC_IDLE: begin
               if (is_bcast) begin
                  if (!mbus_ack_i[i]) begin
                     bc_state_n[i] = BC_PEND;
                     bc_timer_n[i] = '0;
                     bc_cmd_n[i]   = mc;
                     bc_addr_n[i]  = ma;
                  end
`ifdef MESI_ISC_MON_STATS_EN
                  else done_cnt++;
`endif
               end else if (mbus_ack_i[i]) begin
                  ev_port[4][i] = 1'b1;
               end
            end
            BC_PEND: begin
               if (mc != bc_cmd[i] || ma != bc_addr[i]) ev_port[6][i] = 1'b1;
               if (mbus_ack_i[i]) begin
                  bc_state_n[i] = BC_IDLE;
`ifdef MESI_ISC_MON_STATS_EN
                  done_cnt++;
                  if (bc_timer[i] + 1'b1 > lat_max) lat_max = bc_timer[i] + 1'b1;
`endif
               end else if (bc_timer[i] == TIMER_LAST) begin
                  ev_port[5][i] = 1'b1;
                  bc_state_n[i] = BC_IDLE;
               end else begin
                  bc_timer_n[i] = bc_timer[i] + 1'b1;
               end
            end
            default: bc_state_n[i] = BC_IDLE;
         endcase

         case (sn_state[i])
            SN_IDLE: begin
               if (is_snoop && !cbus_ack_i[i]) begin
                  sn_state_n[i] = SN_WAIT;
                  sn_timer_n[i] = '0;
                  sn_cmd_n[i]   = cc;
                  sn_addr_n[i]  = cbus_addr_i;
               end
            end
            SN_WAIT: begin
               if (cc != sn_cmd[i] || cbus_addr_i != sn_addr[i]) ev_port[6][i] = 1'b1;
               if (cbus_ack_i[i]) begin
                  sn_state_n[i] = SN_IDLE;
               end else if (sn_timer[i] == TIMER_LAST) begin
                  ev_port[7][i] = 1'b1;
                  sn_state_n[i] = SN_IDLE;
               end else begin
                  sn_timer_n[i] = sn_timer[i] + 1'b1;
               end
            end
            default: sn_state_n[i] = SN_IDLE;
         endcase
      end

      if (wr_cnt > 1) ev_port[2][0] = 1'b1;
   end

   // Lowest class wins, then lowest port within that class
   always_comb begin
      first_code = '0;
      first_port = '0;
      code_found = 1'b0;
      port_found = 1'b0;
      for (int unsigned c = 0; c < 8; c++) ev[c] = |ev_port[c];
      for (int unsigned c = 0; c < 8; c++) begin
         if (!code_found && ev[c]) begin
            code_found = 1'b1;
            first_code = 3'(c);
            for (int unsigned p = 0; p < CPU_COUNT; p++) begin
               if (!port_found && ev_port[c][p]) begin
                  port_found = 1'b1;
                  first_port = 3'(p);
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ack_q <= '0;
         for (int unsigned i = 0; i < CPU_COUNT; i++) begin
            bc_state[i] <= BC_IDLE;
            bc_timer[i] <= '0;
            bc_cmd[i]   <= '0;
            bc_addr[i]  <= '0;
            sn_state[i] <= SN_IDLE;
            sn_timer[i] <= '0;
            sn_cmd[i]   <= '0;
            sn_addr[i]  <= '0;
         end
      end else begin
         ack_q <= mbus_ack_i;
         for (int unsigned i = 0; i < CPU_COUNT; i++) begin
            bc_state[i] <= bc_state_n[i];
            bc_timer[i] <= bc_timer_n[i];
            bc_cmd[i]   <= bc_cmd_n[i];
            bc_addr[i]  <= bc_addr_n[i];
            sn_state[i] <= sn_state_n[i];
            sn_timer[i] <= sn_timer_n[i];
            sn_cmd[i]   <= sn_cmd_n[i];
            sn_addr[i]  <= sn_addr_n[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clr_i) begin
         err_o            <= '0;
         err_first_code_o <= '0;
         err_first_port_o <= '0;
         err_cnt_o        <= '0;
      end else begin
         err_o <= err_o | ev;
         if (err_o == '0 && ev != '0) begin
            err_first_code_o <= first_code;
            err_first_port_o <= first_port;
         end
         if (ev != '0 && err_cnt_o != '1) err_cnt_o <= err_cnt_o + 1'b1;
      end
   end

   always_comb begin
      busy_o = 1'b0;
      for (int unsigned i = 0; i < CPU_COUNT; i++)
         if (bc_state[i] != BC_IDLE || sn_state[i] != SN_IDLE) busy_o = 1'b1;
   end

`ifdef MESI_ISC_MON_STATS_EN
   assign bcast_sum = {1'b0, stat_bcast_cnt_o} + 17'(done_cnt);

   always_ff @(posedge clk) begin
      if (rst || clr_i) begin
         stat_bcast_cnt_o <= '0;
         stat_max_lat_o   <= '0;
      end else begin
         stat_bcast_cnt_o <= bcast_sum[16] ? '1 : bcast_sum[15:0];
         if (lat_max > stat_max_lat_o) stat_max_lat_o <= lat_max;
      end
   end
`endif

endmodule

// File: tb/tb_mesi_isc_proto_mon.sv
// Scoreboard bench for mesi_isc_proto_mon: directed scenarios plus randomized agent traffic
// checked against a cycle-number/deadline based reference model.
module tb_mesi_isc_proto_mon;
   localparam int N  = 4;
   localparam int AW = 32;
   localparam int MW = 3;
   localparam int CW = 3;
   localparam int TO = 64;
   localparam int TW = 7;
   localparam int EW = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst, clr;
   logic [N*MW-1:0]   mbus_cmd;
   logic [N*AW-1:0]   mbus_addr;
   logic [N-1:0]      mbus_ack;
   logic [N*CW-1:0]   cbus_cmd;
   logic [AW-1:0]     cbus_addr;
   logic [N-1:0]      cbus_ack;
   logic [7:0]        err;
   logic [2:0]        first_code, first_port;
   logic [EW-1:0]     err_cnt;
   logic              busy;
`ifdef MESI_ISC_MON_STATS_EN
   logic [15:0]       stat_cnt;
   logic [TW-1:0]     stat_lat;
`endif

   // bench-side per-port stimulus
   logic [2:0]  mc [N];
   logic [31:0] ma [N];
   logic        mk [N];
   logic [2:0]  cc [N];
   logic        ck [N];
   logic [31:0] caddr;

   always_comb begin
      for (int p = 0; p < N; p++) begin
         mbus_cmd[p*MW +: MW]  = mc[p];
         mbus_addr[p*AW +: AW] = ma[p];
         mbus_ack[p]           = mk[p];
         cbus_cmd[p*CW +: CW]  = cc[p];
         cbus_ack[p]           = ck[p];
      end
      cbus_addr = caddr;
   end

   mesi_isc_proto_mon #(
      .CPU_COUNT(N), .ADDR_WIDTH(AW), .MBUS_CMD_WIDTH(MW), .CBUS_CMD_WIDTH(CW),
      .TIMEOUT_CYCLES(TO), .TIMER_WIDTH(TW), .ERR_CNT_WIDTH(EW)
   ) dut (
      .clk(clk), .rst(rst), .clr_i(clr),
      .mbus_cmd_i(mbus_cmd), .mbus_addr_i(mbus_addr), .mbus_ack_i(mbus_ack),
      .cbus_cmd_i(cbus_cmd), .cbus_addr_i(cbus_addr), .cbus_ack_i(cbus_ack),
`ifdef MESI_ISC_MON_STATS_EN
      .stat_bcast_cnt_o(stat_cnt), .stat_max_lat_o(stat_lat),
`endif
      .err_o(err), .err_first_code_o(first_code), .err_first_port_o(first_port),
      .err_cnt_o(err_cnt), .busy_o(busy)
   );

   typedef struct {
      logic [7:0]    err;
      logic [2:0]    code;
      logic [2:0]    port;
      logic [EW-1:0] cnt;
      logic          busy;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   // reference model: pending transfers tracked by issue deadline (cycle number)
   int          cyc = 0;
   bit          bc_pend [N];
   int          bc_dl   [N];
   logic [2:0]  bc_c    [N];
   logic [31:0] bc_a    [N];
   bit          sn_pend [N];
   int          sn_dl   [N];
   logic [2:0]  sn_c    [N];
   logic [31:0] sn_a    [N];
   bit          pk      [N];
   logic [7:0]  m_err;
   int          m_code, m_port, m_cnt;

   task automatic model_step();
      bit [N-1:0] evm [8];
      bit [7:0]   evv;
      int         nwr;
      exp_t       e;
      cyc++;
      for (int c = 0; c < 8; c++) evm[c] = '0;
      evv = '0;
      nwr = 0;
      if (rst) begin
         for (int p = 0; p < N; p++) begin
            bc_pend[p] = 0; sn_pend[p] = 0; pk[p] = 0;
         end
         m_err = '0; m_code = 0; m_port = 0; m_cnt = 0;
      end else begin
         for (int p = 0; p < N; p++) begin
            if (mc[p] > 4) evm[0][p] = 1;
            if (cc[p] > 4) evm[1][p] = 1;
            if (mc[p] == 1) nwr++;
            if (mk[p] && pk[p]) evm[3][p] = 1;
            if (!bc_pend[p]) begin
               if (mc[p] == 3 || mc[p] == 4) begin
                  if (!mk[p]) begin
                     bc_pend[p] = 1; bc_dl[p] = cyc + TO; bc_c[p] = mc[p]; bc_a[p] = ma[p];
                  end
               end else if (mk[p]) evm[4][p] = 1;
            end else begin
               if (mc[p] != bc_c[p] || ma[p] != bc_a[p]) evm[6][p] = 1;
               if (mk[p]) bc_pend[p] = 0;
               else if (cyc == bc_dl[p]) begin evm[5][p] = 1; bc_pend[p] = 0; end
            end
            if (!sn_pend[p]) begin
               if (cc[p] >= 1 && cc[p] <= 4 && !ck[p]) begin
                  sn_pend[p] = 1; sn_dl[p] = cyc + TO; sn_c[p] = cc[p]; sn_a[p] = caddr;
               end
            end else begin
               if (cc[p] != sn_c[p] || caddr != sn_a[p]) evm[6][p] = 1;
               if (ck[p]) sn_pend[p] = 0;
               else if (cyc == sn_dl[p]) begin evm[7][p] = 1; sn_pend[p] = 0; end
            end
            pk[p] = mk[p];
         end
         if (nwr > 1) evm[2][0] = 1;
         for (int c = 0; c < 8; c++) evv[c] = (evm[c] != 0);
         if (clr) begin
            m_err = '0; m_code = 0; m_port = 0; m_cnt = 0;
         end else begin
            if (m_err == 0 && evv != 0) begin
               for (int c = 0; c < 8; c++) if (evv[c]) begin m_code = c; break; end
               for (int p = 0; p < N; p++) if (evm[m_code][p]) begin m_port = p; break; end
            end
            m_err = m_err | evv;
            if (evv != 0 && m_cnt < (1 << EW) - 1) m_cnt++;
         end
      end
      e.err  = m_err;
      e.code = 3'(m_code);
      e.port = 3'(m_port);
      e.cnt  = EW'(m_cnt);
      e.busy = 0;
      for (int p = 0; p < N; p++) if (bc_pend[p] || sn_pend[p]) e.busy = 1;
      exp_q.push_back(e);
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s at t=%0t: got 0x%0h expected 0x%0h", nm, $time, act, want);
      end
   endtask

   // monitor: one expected record per clock, sampled 1 time unit after the edge
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("err_o",            32'(err),        32'(e.err));
            check("err_first_code_o", 32'(first_code), 32'(e.code));
            check("err_first_port_o", 32'(first_port), 32'(e.port));
            check("err_cnt_o",        32'(err_cnt),    32'(e.cnt));
            check("busy_o",           32'(busy),       32'(e.busy));
         end
      end
   end

   task automatic idle_inputs();
      for (int p = 0; p < N; p++) begin
         mc[p] = 0; ma[p] = 0; mk[p] = 0; cc[p] = 0; ck[p] = 0;
      end
      caddr = 0;
   endtask

   task automatic step();
      model_step();
      @(negedge clk);
   endtask

   task automatic do_clr();
      clr = 1; step(); clr = 0;
   endtask

   int bw [N];
   int sw [N];

   initial begin
      rst = 1; clr = 0;
      idle_inputs();
      @(negedge clk);
      repeat (3) step();
      rst = 0;
      repeat (2) step();

      // clean broadcast, ack after 5 pending cycles
      mc[0] = 3; ma[0] = 32'h1; step();
      repeat (4) step();
      mk[0] = 1; step();
      mk[0] = 0; mc[0] = 0; repeat (2) step();

      // two simultaneous plain writes
      mc[1] = 1; mc[2] = 1; step();
      mc[1] = 0; mc[2] = 0; repeat (2) step();
      do_clr(); step();

      // broadcast timeout on port 2
      mc[2] = 4; ma[2] = 32'h40; repeat (66) step();
      mc[2] = 0; repeat (2) step();
      do_clr(); step();

      // snoop with unstable shared address
      cc[1] = 1; caddr = 32'h555; step();
      caddr = 32'h556; step();
      ck[1] = 1; step();
      ck[1] = 0; cc[1] = 0; repeat (2) step();
      do_clr(); step();

      // double ack after a valid broadcast, then clear
      mc[0] = 3; ma[0] = 32'h80; step();
      mk[0] = 1; step();
      mc[0] = 0; step();
      mk[0] = 0; step();
      do_clr(); repeat (2) step();

      // illegal command held long enough to saturate the counter
      mc[3] = 7; repeat (300) step();
      mc[3] = 0; step();
      do_clr(); step();

      // randomized agents with occasional corruption, clears and resets
      for (int p = 0; p < N; p++) begin bw[p] = -1; sw[p] = -1; end
      repeat (3000) begin
         for (int p = 0; p < N; p++) begin
            mk[p] = 0;
            if (bw[p] == -1) begin
               mc[p] = 0;
               if ($urandom_range(0, 9) == 0) begin
                  mc[p] = 3'($urandom_range(3, 4));
                  ma[p] = $urandom;
                  bw[p] = ($urandom_range(0, 19) == 0) ? 70 : int'($urandom_range(0, 6));
               end else if ($urandom_range(0, 29) == 0) begin
                  mc[p] = 3'($urandom_range(1, 2));
               end
            end
            if (bw[p] >= 0) begin
               if (bw[p] == 0) begin mk[p] = 1; bw[p] = -1; end
               else bw[p]--;
            end
            ck[p] = 0;
            if (sw[p] == -1) begin
               cc[p] = 0;
               if ($urandom_range(0, 9) == 0) begin
                  cc[p] = 3'($urandom_range(1, 4));
                  sw[p] = ($urandom_range(0, 19) == 0) ? 70 : int'($urandom_range(0, 5));
               end
            end
            if (sw[p] >= 0) begin
               if (sw[p] == 0) begin ck[p] = 1; sw[p] = -1; end
               else sw[p]--;
            end
            if ($urandom_range(0, 99) < 2) begin
               case ($urandom_range(0, 3))
                  0: mc[p] = 3'($urandom_range(0, 7));
                  1: mk[p] = ~mk[p];
                  2: ma[p] = ma[p] ^ 32'h10;
                  default: cc[p] = 3'($urandom_range(0, 7));
               endcase
            end
         end
         if ($urandom_range(0, 99) < 3) caddr = $urandom;
         clr = ($urandom_range(0, 99) < 2);
         rst = ($urandom_range(0, 499) == 0);
         step();
      end
      clr = 0; rst = 0;
      idle_inputs();
      step();

      repeat (2) @(posedge clk);
      #2;
      check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
